// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port, byte-split
// 16-bit RAM with registered read; single-byte writes become read-modify-write.
module ram_port_arbiter #(
    parameter int AW    = 10,
    parameter int DW    = 16,
    parameter int DEPTH = 10
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_wr,
    input  logic [1:0]    req0_be,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_wr,
    input  logic [1:0]    req1_be,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,

    output logic          ram_rst_n,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_datain,
    output logic          ram_wr,
    input  logic [DW-1:0] ram_dataout
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDATA,
        RMW_RD,
        RMW_WR
    } state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t        state;
    state_t        state_nx;

    logic          ptr;
    logic          cmd_id;
    logic [1:0]    cmd_be;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] datain_q;

    logic          grant;
    logic          gnt_id;
    logic          sel_wr;
    logic [1:0]    sel_be;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          cmd_in_range;
    logic          cmd_wr_en;
    logic [DW-1:0] merged;
    logic [DW-1:0] rd_val;

    assign ram_rst_n = ~reset;

    // Pointer holds the last-granted id; on contention the other id wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant  = 1'b0;
        gnt_id = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant  = 1'b1;
                gnt_id = ~ptr;
            end else if (req0_valid) begin
                grant  = 1'b1;
                gnt_id = 1'b0;
            end else if (req1_valid) begin
                grant  = 1'b1;
                gnt_id = 1'b1;
            end
        end
    end

    assign req0_ready = grant & ~gnt_id;
    assign req1_ready = grant &  gnt_id;

    assign sel_wr    = gnt_id ? req1_wr    : req0_wr;
    assign sel_be    = gnt_id ? req1_be    : req0_be;
    assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
    assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (!sel_wr)
                        state_nx = READ;
                    else if (sel_be == 2'b01 || sel_be == 2'b10)
                        state_nx = RMW_RD;
                    else
                        state_nx = WRITE;
                end
            end
            WRITE:   state_nx = IDLE;
            READ:    state_nx = RDATA;
            RDATA:   state_nx = IDLE;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_in_range = (cmd_addr < DEPTH_A);
    // An all-zero byte mask or an out-of-range address walks the states without writing.
    assign cmd_wr_en    = cmd_in_range && (cmd_be != 2'b00);

    assign merged = {cmd_be[1] ? cmd_wdata[DW-1:8] : ram_dataout[DW-1:8],
                     cmd_be[0] ? cmd_wdata[7:0]    : ram_dataout[7:0]};
    assign rd_val = cmd_in_range ? ram_dataout : '0;

    assign ram_addr   = addr_q;
    assign ram_datain = (state == RMW_WR) ? merged : datain_q;
    assign ram_wr     = !reset && cmd_wr_en && (state == WRITE || state == RMW_WR);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_be     <= 2'b00;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            addr_q     <= '0;
            datain_q   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= state_nx;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            if (grant) begin
                ptr       <= gnt_id;
                cmd_id    <= gnt_id;
                cmd_be    <= sel_be;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
                addr_q    <= sel_addr;
                if (sel_wr && sel_be != 2'b01 && sel_be != 2'b10)
                    datain_q <= sel_wdata;
            end

            // Keep the merged word so ram_datain holds it once back in IDLE.
            if (state == RMW_WR)
                datain_q <= merged;

            if (state == RDATA) begin
                if (cmd_id) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= rd_val;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= rd_val;
                end
            end
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter and sequencer for the single-port, byte-split 16-bit RAM (`ram8k16`-style: separate low/high byte arrays, registered read, no byte enables). The block accepts read and write commands from two clients and drives the RAM's address, data and write strobe. Partial (single-byte) writes are handled as read-modify-write, so the RAM itself needs no byte-enable port. It sits between the bus-side clients and the RAM instance; the RAM is reset only through this block.

## Interface
- `AW`, 10, address width
- `DW`, 16, data width; fixed at 2 bytes
- `DEPTH`, 10, number of implemented RAM words; addresses ≥ DEPTH are out of range
- `clk` in 1 — single clock, all logic on posedge
- `reset` in 1 — synchronous, active-high
- `reqN_valid` in 1 (N=0,1) — command present
- `reqN_ready` out 1 — command accepted this cycle
- `reqN_wr` in 1 — 1 = write, 0 = read
- `reqN_be` in 2 — byte enables for writes; bit0 = [7:0], bit1 = [15:8]; ignored for reads
- `reqN_addr` in AW — word address
- `reqN_wdata` in DW — write data
- `rspN_valid` out 1 — one-cycle read-data pulse to requester N
- `rspN_rdata` out DW — read data, valid while `rspN_valid`=1
- `ram_rst_n` out 1 — RAM reset (active-low) = ~reset, combinational
- `ram_addr` out AW, `ram_datain` out DW, `ram_wr` out 1 — RAM command
- `ram_dataout` in DW — RAM registered read data

## Operation
- States: IDLE, WRITE, READ, RDATA, RMW_RD, RMW_WR.
- IDLE: if any `reqN_valid`, grant one requester; `reqN_ready`=1 combinationally for the granted requester only. The command (id, wr, be, addr, wdata) is latched on that edge. Ready is 0 in every other state.
- Round-robin: the pointer holds the last-granted id. If both requesters are valid, the other id wins. If one is valid, it wins. The pointer updates only on a grant.
- Next state after a grant:
  - Read → READ.
  - Write with be=11 → WRITE.
  - Write with be=01 or 10 → RMW_RD.
  - Write with be=00 → WRITE with `ram_wr` forced 0 (no-op, still occupies the slot).
- WRITE: `ram_wr`=1, `ram_addr`/`ram_datain` = latched values → IDLE.
- READ: `ram_wr`=0, `ram_addr`=latched addr → RDATA.
- RDATA: capture `ram_dataout` into `rspN_rdata` of the latched id and set `rspN_valid` for one cycle → IDLE.
- RMW_RD: `ram_wr`=0, `ram_addr`=addr → RMW_WR.
- RMW_WR: `ram_wr`=1, `ram_datain` = per byte, wdata byte if its be bit is set, else `ram_dataout` byte → IDLE.
- Out of range (addr ≥ DEPTH):
  - Writes run the normal state sequence with `ram_wr`=0 throughout.
  - Reads return 0.
- Writes produce no response; the requester treats `ready` as completion.
- `ram_addr` and `ram_datain` hold their last values in IDLE; `ram_wr`=0 in IDLE.

## Timing
- Grant at cycle T (valid & ready high). The RAM is driven from T+1.
- Full write: RAM written at the end of T+1. The next grant is possible at T+2.
- Read: RAM read issued at T+1, `ram_dataout` valid at T+2, `rspN_valid`/`rdata` high at T+3. The next grant is possible at T+3, so a read response may coincide with the next grant.
- Partial write: read at T+1, merged write at the end of T+2. The next grant is possible at T+3.
- Back-to-back throughput: one command per 2 cycles for writes, one per 3 cycles for reads and RMW.
- A requester must hold valid and its command stable until ready. Dropping valid before grant withdraws the request.
- Reset values: state=IDLE, pointer=1 (req0 wins first), `reqN_ready`=0, `rspN_valid`=0, `rspN_rdata`=0, `ram_wr`=0, `ram_addr`=0, `ram_datain`=0.
- Reset mid-operation:
  - An in-flight command is aborted with no RAM write and no response.
  - RAM contents are cleared via `ram_rst_n`.
  - No grant occurs in any cycle where reset=1.

## Test plan
- After reset, req0 writes addr 3, be=11, data 0xBEEF; then req0 reads addr 3 → `rsp0_valid` 3 cycles after the read grant, `rsp0_rdata`=0xBEEF.
- Both requesters are valid continuously with reads to different addresses → grants alternate 0,1,0,1, starting with req0; each response goes only to the owning id.
- Write 0x1234 to addr 5, then a partial write be=10 with data 0xAB00 → a read of addr 5 returns 0xAB34; with be=01 and data 0x00CD it returns 0xAB34 → 0xABCD.
- Write be=00 to addr 2 holding 0x5555 → `ram_wr` never high; a later read returns 0x5555. Write to addr 12 (≥ DEPTH) → `ram_wr`=0; a read of addr 12 returns 0.
- Assert reset during RMW_RD of a partial write → no `ram_wr` pulse, state returns to IDLE, reads of all addresses return 0.
